// File: rtl/assoc_tag_mem.sv
// ----------------------------------------------------------------------------
// assoc_tag_mem
//
// N-way set-associative tag store for the L1 data cache. Each set holds a
// tag, valid bit and dirty bit per way plus a tree pseudo-LRU state of
// NUM_WAYS-1 bits. One lookup per cycle is accepted and answered on the next
// cycle with hit/way/dirty and the replacement victim for the set. After
// reset, and on request, the valid/dirty/PLRU state is cleared by a sweep that
// visits one set per cycle. Tags are never cleared.
//
// Ports
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   lookup_*_i / _ready_o   lookup request channel
//   resp_*_o                registered lookup response (held until next accept)
//   wr_*_i                  fill port (tag write, sets valid)
//   inval_all_i             start an invalidate sweep (ignored while busy)
//   busy_o                  sweep in progress
//   dbg_state_o             FSM state (1 = sweeping)
//   dbg_sweep_cnt_o         set currently being cleared by the sweep
//
// Handshake: a lookup is accepted on a rising edge where lookup_valid_i and
// lookup_ready_o are both high; lookup_ready_o is simply !busy_o and does not
// depend on lookup_valid_i. resp_valid_o pulses for exactly one cycle after
// each accept; the other resp_* outputs keep their value until the next
// accept. Fills have no ready: a fill presented while busy_o is dropped.
// ----------------------------------------------------------------------------
module assoc_tag_mem #(
    parameter  int NUM_SETS = 64,
    parameter  int NUM_WAYS = 4,
    parameter  int TAG_W    = 20,
    localparam int IDX_W    = $clog2(NUM_SETS),
    localparam int WAY_W    = $clog2(NUM_WAYS)
) (
    input  logic             clk_i,
    input  logic             rst_ni,

    input  logic             lookup_valid_i,
    output logic             lookup_ready_o,
    input  logic [IDX_W-1:0] lookup_index_i,
    input  logic [TAG_W-1:0] lookup_tag_i,
    input  logic             lookup_wr_i,

    output logic             resp_valid_o,
    output logic             resp_hit_o,
    output logic [WAY_W-1:0] resp_way_o,
    output logic             resp_dirty_o,
    output logic [WAY_W-1:0] resp_victim_way_o,
    output logic             resp_victim_valid_o,
    output logic             resp_victim_dirty_o,
    output logic [TAG_W-1:0] resp_victim_tag_o,

    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_index_i,
    input  logic [WAY_W-1:0] wr_way_i,
    input  logic [TAG_W-1:0] wr_tag_i,
    input  logic             wr_dirty_i,

    input  logic             inval_all_i,
    output logic             busy_o,

    output logic [0:0]       dbg_state_o,
    output logic [IDX_W-1:0] dbg_sweep_cnt_o
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_e;

    // ------------------------------------------------------------------------
    // PLRU helpers. Node n has children 2n+1 / 2n+2, leaves are ways in
    // ascending order, a 0 bit points to the lower half. Node selection is
    // done by comparing against every node index so that all bit-selects use
    // constant indices.
    // ------------------------------------------------------------------------
    function automatic logic [WAY_W-1:0] plru_victim(input logic [NUM_WAYS-2:0] bits);
        logic [WAY_W-1:0] way;
        int               node;
        logic             b;
        way  = '0;
        node = 0;
        for (int l = 0; l < WAY_W; l++) begin
            b = 1'b0;
            for (int n = 0; n < NUM_WAYS - 1; n++) begin
                if (n == node) b = bits[n];
            end
            way[WAY_W-1-l] = b;
            node = 2 * node + (b ? 2 : 1);
        end
        return way;
    endfunction

    // Every node on the path to way w is turned to point away from w.
    function automatic logic [NUM_WAYS-2:0] plru_access(input logic [NUM_WAYS-2:0] bits,
                                                         input logic [WAY_W-1:0]    w);
        logic [NUM_WAYS-2:0] res;
        int                  node;
        logic                dir;
        res  = bits;
        node = 0;
        for (int l = 0; l < WAY_W; l++) begin
            dir = w[WAY_W-1-l];
            for (int n = 0; n < NUM_WAYS - 1; n++) begin
                if (n == node) res[n] = ~dir;
            end
            node = 2 * node + (dir ? 2 : 1);
        end
        return res;
    endfunction

    // ------------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------------
    logic [TAG_W-1:0]    tag_q   [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0] dirty_q [NUM_SETS];
    logic [NUM_WAYS-2:0] plru_q  [NUM_SETS];

    // ------------------------------------------------------------------------
    // Sweep FSM
    // ------------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             busy;

    assign busy = (state_q == ST_SWEEP);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_SWEEP;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_SWEEP: begin
                cnt_d = cnt_q + IDX_W'(1);
                if (cnt_q == IDX_W'(NUM_SETS - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            ST_IDLE: begin
                // A lookup accepted this same cycle still completes normally;
                // the sweep begins clearing on the following edge.
                if (inval_all_i) begin
                    state_d = ST_SWEEP;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_SWEEP;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy_o          = busy;
    assign lookup_ready_o  = !busy;
    assign dbg_state_o     = state_q;
    assign dbg_sweep_cnt_o = cnt_q;

    // ------------------------------------------------------------------------
    // Lookup compare and victim selection (combinational, pre-update state)
    // ------------------------------------------------------------------------
    logic                lk_accept;
    logic                fill_en;
    logic [NUM_WAYS-1:0] valid_set;
    logic [NUM_WAYS-1:0] dirty_set;
    logic [NUM_WAYS-2:0] plru_set;
    logic [NUM_WAYS-1:0] hit_vec;
    logic                lk_hit;
    logic [WAY_W-1:0]    lk_way;
    logic                lk_dirty;
    logic [WAY_W-1:0]    vic_way;
    logic                vic_valid;
    logic                vic_dirty;
    logic [TAG_W-1:0]    vic_tag;

    assign lk_accept = lookup_valid_i && !busy;
    assign fill_en   = wr_en_i && !busy;

    assign valid_set = valid_q[lookup_index_i];
    assign dirty_set = dirty_q[lookup_index_i];
    assign plru_set  = plru_q[lookup_index_i];

    always_comb begin
        hit_vec = '0;
        lk_way  = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            hit_vec[w] = valid_set[w] && (tag_q[lookup_index_i][w] == lookup_tag_i);
        end
        // Descending scan so the lowest matching way wins should duplicates
        // ever exist.
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (hit_vec[w]) lk_way = WAY_W'(w);
        end
        lk_hit   = |hit_vec;
        lk_dirty = lk_hit && dirty_set[lk_way];
    end

    always_comb begin
        vic_way = plru_victim(plru_set);
        // Any invalid way overrides the PLRU choice; lowest index first.
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid_set[w]) vic_way = WAY_W'(w);
        end
        vic_valid = valid_set[vic_way];
        vic_dirty = dirty_set[vic_way];
        vic_tag   = tag_q[lookup_index_i][vic_way];
    end

    // ------------------------------------------------------------------------
    // State update. The fill assignments come after the lookup ones, so when
    // both touch the same set's PLRU or the same way's dirty bit, the fill's
    // value is the one that lands.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (busy) begin
            valid_q[cnt_q] <= '0;
            dirty_q[cnt_q] <= '0;
            plru_q[cnt_q]  <= '0;
        end else begin
            if (lk_accept && lk_hit) begin
                plru_q[lookup_index_i] <= plru_access(plru_set, lk_way);
                if (lookup_wr_i) dirty_q[lookup_index_i][lk_way] <= 1'b1;
            end
            if (fill_en) begin
                tag_q[wr_index_i][wr_way_i]   <= wr_tag_i;
                valid_q[wr_index_i][wr_way_i] <= 1'b1;
                dirty_q[wr_index_i][wr_way_i] <= wr_dirty_i;
                plru_q[wr_index_i]            <= plru_access(plru_q[wr_index_i], wr_way_i);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Response registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resp_valid_o        <= 1'b0;
            resp_hit_o          <= 1'b0;
            resp_way_o          <= '0;
            resp_dirty_o        <= 1'b0;
            resp_victim_way_o   <= '0;
            resp_victim_valid_o <= 1'b0;
            resp_victim_dirty_o <= 1'b0;
            resp_victim_tag_o   <= '0;
        end else begin
            resp_valid_o <= lk_accept;
            if (lk_accept) begin
                resp_hit_o          <= lk_hit;
                resp_way_o          <= lk_way;
                resp_dirty_o        <= lk_dirty;
                resp_victim_way_o   <= vic_way;
                resp_victim_valid_o <= vic_valid;
                resp_victim_dirty_o <= vic_dirty;
                resp_victim_tag_o   <= vic_tag;
            end
        end
    end

endmodule
